// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential floating-point divider.
package fp_div_pkg;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_DIV   = 2'd1;
  localparam state_t S_ROUND = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int NUM_FLAGS   = 5;
  localparam int FLG_INVALID = 4;
  localparam int FLG_DIVZERO = 3;
  localparam int FLG_OVERFLOW = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN, positive sign, MSB of the mantissa set; caller truncates to W.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int mant_w);
    return (((64'd1 << exp_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
  endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq; flags exist only with FP_DIV_FLAGS_EN.
interface fp_div_seq_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         out_exc;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]   flags;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, out_exc
`ifdef FP_DIV_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, out_exc
`ifdef FP_DIV_FLAGS_EN
    , output flags
`endif
  );
endinterface

// File: rtl/fp_div_special.sv
// Combinational operand classifier: NaN/Inf/zero cases resolved without dividing.
module fp_div_special import fp_div_pkg::*; #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  output logic                  is_special,
  output logic [EXP_W+MANT_W:0] res,
  output logic                  invalid,
  output logic                  divzero
);
  localparam int W = 1 + EXP_W + MANT_W;
  localparam logic [W-1:0] QNAN = W'(fp_canon_nan(EXP_W, MANT_W));

  logic a_ones, b_ones, a_mz, b_mz;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic [W-1:0] inf_s, zero_s;

  assign a_ones = &a[W-2 -: EXP_W];
  assign b_ones = &b[W-2 -: EXP_W];
  assign a_mz   = ~|a[MANT_W-1:0];
  assign b_mz   = ~|b[MANT_W-1:0];
  assign a_nan  = a_ones & ~a_mz;
  assign b_nan  = b_ones & ~b_mz;
  assign a_inf  = a_ones & a_mz;
  assign b_inf  = b_ones & b_mz;
  // Subnormals are flushed: any zero exponent counts as zero.
  assign a_zero = ~|a[W-2 -: EXP_W];
  assign b_zero = ~|b[W-2 -: EXP_W];
  assign sgn    = a[W-1] ^ b[W-1];
  assign inf_s  = {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
  assign zero_s = {sgn, {(W-1){1'b0}}};

  always_comb begin
    is_special = 1'b1;
    res        = '0;
    invalid    = 1'b0;
    divzero    = 1'b0;
    if (a_nan) begin
      res = a; invalid = 1'b1;
    end else if (b_nan) begin
      res = b; invalid = 1'b1;
    end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
      res = QNAN; invalid = 1'b1;
    end else if (a_inf) begin
      res = inf_s;
    end else if (b_inf) begin
      res = zero_s;
    end else if (b_zero) begin
      res = inf_s; divzero = 1'b1;
    end else if (a_zero) begin
      res = zero_s;
    end else begin
      is_special = 1'b0;
    end
  end
endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-style divider: restoring mantissa division, one bit per cycle, RNE rounding.
// Define FP_DIV_FLAGS_EN to add the exception flags output.
module fp_div_seq import fp_div_pkg::*; #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_div_seq_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int QW = MANT_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [EW-1:0] BIAS   = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S = '0;

  state_t                 state;
  logic                   sign_r;
  logic signed [EW-1:0]   exp_r;
  logic [MANT_W:0]        div_r;
  logic [MANT_W+1:0]      rem_r;
  logic [QW-1:0]          quo_r;
  logic [CW-1:0]          cnt_r;
  logic [W-1:0]           q_r;
  logic                   exc_r;

  logic         sp_is;
  logic [W-1:0] sp_res;
`ifdef FP_DIV_FLAGS_EN
  logic                 sp_inv, sp_dz;
  logic [NUM_FLAGS-1:0] flags_r, rnd_flags;
`endif

  fp_div_special #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_special (
    .a          (bus.a),
    .b          (bus.b),
    .is_special (sp_is),
    .res        (sp_res),
`ifdef FP_DIV_FLAGS_EN
    .invalid    (sp_inv),
    .divzero    (sp_dz)
`else
    .invalid    (),
    .divzero    ()
`endif
  );

  // Restoring step: remainder stays below the divisor, so the shifted value never overflows.
  logic              rem_ge;
  logic [MANT_W+1:0] rem_sub;
  assign rem_ge  = rem_r >= {1'b0, div_r};
  assign rem_sub = rem_ge ? rem_r - {1'b0, div_r} : rem_r;

  logic                 guard, sticky, rnd_up, ovf, unf;
  logic [MANT_W-1:0]    mant_t;
  logic [MANT_W:0]      mant_rnd;
  logic signed [EW-1:0] exp_adj, exp_f;
  logic [W-1:0]         rnd_q;

  always_comb begin
    if (quo_r[QW-1]) begin
      mant_t  = quo_r[QW-2:2];
      guard   = quo_r[1];
      sticky  = quo_r[0] | (|rem_r);
      exp_adj = exp_r;
    end else begin
      // Quotient below 1.0: the next bit is the leading one.
      mant_t  = quo_r[QW-3:1];
      guard   = quo_r[0];
      sticky  = |rem_r;
      exp_adj = exp_r - ONE_S;
    end
    rnd_up   = guard & (sticky | mant_t[0]);
    mant_rnd = {1'b0, mant_t} + {{MANT_W{1'b0}}, rnd_up};
    exp_f    = exp_adj + $signed({{(EW-1){1'b0}}, mant_rnd[MANT_W]});
    ovf      = exp_f >= EMAX;
    unf      = exp_f <= ZERO_S;
    if (ovf)      rnd_q = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else if (unf) rnd_q = {sign_r, {(W-1){1'b0}}};
    else          rnd_q = {sign_r, exp_f[EXP_W-1:0], mant_rnd[MANT_W-1:0]};
  end

`ifdef FP_DIV_FLAGS_EN
  always_comb begin
    rnd_flags                = '0;
    rnd_flags[FLG_OVERFLOW]  = ovf;
    rnd_flags[FLG_UNDERFLOW] = unf & ~ovf;
    rnd_flags[FLG_INEXACT]   = ovf | unf | guard | sticky;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sign_r <= 1'b0;
      exp_r  <= '0;
      div_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      cnt_r  <= '0;
      q_r    <= '0;
      exc_r  <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
      flags_r <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          if (sp_is) begin
            q_r   <= sp_res;
            exc_r <= 1'b1;
`ifdef FP_DIV_FLAGS_EN
            flags_r              <= '0;
            flags_r[FLG_INVALID] <= sp_inv;
            flags_r[FLG_DIVZERO] <= sp_dz;
`endif
            state <= S_DONE;
          end else begin
            sign_r <= bus.a[W-1] ^ bus.b[W-1];
            exp_r  <= $signed({2'b00, bus.a[W-2 -: EXP_W]})
                    - $signed({2'b00, bus.b[W-2 -: EXP_W]}) + BIAS;
            div_r  <= {1'b1, bus.b[MANT_W-1:0]};
            rem_r  <= {2'b01, bus.a[MANT_W-1:0]};
            quo_r  <= '0;
            cnt_r  <= '0;
            state  <= S_DIV;
          end
        end
        S_DIV: begin
          rem_r <= {rem_sub[MANT_W:0], 1'b0};
          quo_r <= {quo_r[QW-2:0], rem_ge};
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(QW - 1)) state <= S_ROUND;
        end
        S_ROUND: begin
          q_r   <= rnd_q;
          exc_r <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
          flags_r <= rnd_flags;
`endif
          state <= S_DONE;
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.q         = q_r;
  assign bus.out_exc   = exc_r;
`ifdef FP_DIV_FLAGS_EN
  assign bus.flags     = flags_r;
`endif
endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MANT_W, default 10, stored mantissa width; W = 1+EXP_W+MANT_W (default 16, binary16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  W  dividend, IEEE-754 layout {sign, exp, mant}.
REQ-008 SHALL have port b  input  W  divisor, same layout.
REQ-009 SHALL have port out_valid  output  1  result held.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port q  output  W  quotient.
REQ-012 SHALL have port out_exc  output  1  result came from the special-case path.

Function
REQ-013 SHALL run FSM IDLE -> (DIV -> ROUND | special) -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept on the edge with in_valid & in_ready and capture a, b; in_valid outside IDLE is ignored.
REQ-015 SHALL classify at accept, in priority order: a NaN -> a unchanged; b NaN -> b unchanged; Inf/Inf or 0/0 -> canonical NaN {0, all-ones exp, 1, zeros} (0x7E00); Inf/finite -> signed Inf; finite/Inf -> signed zero; nonzero/0 -> signed Inf; 0/nonzero -> signed zero; sign = sign(a) ^ sign(b) except NaN cases.
REQ-016 SHALL treat exp = 0 operands (zero or subnormal) as signed zero.
REQ-017 SHALL, on a special case, register q, set out_exc = 1 and enter DONE at the accept edge (out_valid high the following cycle).
REQ-018 SHALL otherwise run restoring division of {1, mant_a} by {1, mant_b}, one quotient bit per cycle, MANT_W+3 cycles in DIV (integer, MANT_W fraction, guard, round bits).
REQ-019 SHALL in ROUND: if integer bit is 0, shift left one and decrement exponent; sticky = leftover bit OR remainder != 0; round-to-nearest-even; mantissa carry-out increments exponent.
REQ-020 SHALL compute exponent as exp_a - exp_b + bias (2^(EXP_W-1)-1) in EXP_W+2 signed bits; result >= all-ones -> signed Inf; result <= 0 -> signed zero (flush).
REQ-021 SHALL give out_valid exactly MANT_W+4 edges after accept on the normal path (14 at defaults), out_exc = 0.
REQ-022 SHALL hold q, out_exc, out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge.

Reset
REQ-023 SHALL on rst_n = 0 immediately force IDLE, in_ready = 1 after release, out_valid = 0, q = 0, out_exc = 0, all datapath registers 0.
REQ-024 SHALL discard any in-flight operation on reset mid-DIV/ROUND/DONE, with no result produced.

Configuration
REQ-025 SHALL, with FP_DIV_FLAGS_EN defined, add output port flags [4:0] = {invalid, divzero, overflow, underflow, inexact}, registered with q, held in DONE, reset to 0; invalid for Inf/Inf, 0/0 or any NaN operand; divzero for nonzero/0; overflow and underflow per REQ-020 (both also set inexact); inexact when guard|sticky.
REQ-026 SHALL, without FP_DIV_FLAGS_EN, have no flags port or flag logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the FSM state enum, canonical-NaN and bias constants (functions of EXP_W/MANT_W) and flag bit indices in package fp_div_pkg.
REQ-028 SHALL implement classification (REQ-015/016) in combinational sub-module fp_div_special, parametrised by EXP_W/MANT_W, outputs is_special, special result, invalid, divzero.

Verification
REQ-029 SHALL check a=0x4200, b=0x3E00 (3/1.5) -> q=0x4000, out_exc=0, out_valid 14 edges after accept.
REQ-030 SHALL check a=0x3C00, b=0x4200 (1/3) -> q=0x3555, flags inexact=1 when FP_DIV_FLAGS_EN.
REQ-031 SHALL check a=0x3C00, b=0x0000 -> q=0x7C00, out_exc=1, out_valid 1 edge after accept, divzero=1; a=0x0000, b=0x8000 -> q=0x7E00, invalid=1.
REQ-032 SHALL check a=0x7BFF, b=0x3800 -> q=0x7C00, overflow=1, inexact=1.
REQ-033 SHALL check out_ready held low 5 cycles in DONE -> q stable, in_ready=0, second in_valid ignored; result consumed on first out_ready=1 edge.
REQ-034 SHALL check rst_n pulsed low during DIV -> out_valid=0, q=0 immediately; next operation 0x4200/0x3E00 completes normally with q=0x4000.
